// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Collects level reset requests from several requesters. It holds every reset
// domain in reset for a minimum quiet period, then releases the domains one at
// a time with a fixed gap between releases (domain 0 first). Any request seen
// during the hold or during the staged release restarts the whole sequence.
// It also records which requesters caused resets.
//
// Ports
//   clk_i          : clock for all state
//   rst_ni         : asynchronous active-low reset (power-on sequence follows)
//   rst_req_i      : [NumReq] level reset requests, synchronous to clk_i
//   cause_clr_i    : one-cycle pulse that clears rst_cause_o
//   domain_rst_no  : [NumDomains] active-low domain resets, bit 0 released first
//   seq_busy_o     : high while any domain is held or release is in progress
//   rst_cause_o    : [NumReq] sticky OR of all requests since the last clear
//   last_cause_o   : [NumReq] requests that started/extended the latest sequence
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int NumReq       = 4,
    parameter int NumDomains   = 3,
    parameter int AssertCycles = 16,
    parameter int StageGap     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumReq-1:0]     rst_req_i,
    input  logic                  cause_clr_i,
    output logic [NumDomains-1:0] domain_rst_no,
    output logic                  seq_busy_o,
    output logic [NumReq-1:0]     rst_cause_o,
    output logic [NumReq-1:0]     last_cause_o
);

    localparam int MaxCount = (AssertCycles > StageGap) ? AssertCycles : StageGap;
    localparam int CntW     = $clog2(MaxCount + 1);
    localparam int StgW     = $clog2(NumDomains + 1);

    // Terminal values are one below the cycle counts: the transition happens
    // on the edge at which the counter would reach the full count.
    localparam logic [CntW-1:0] AssertLast = CntW'(AssertCycles - 1);
    localparam logic [CntW-1:0] GapLast    = CntW'(StageGap - 1);
    localparam logic [CntW-1:0] CntSat     = CntW'(MaxCount);
    localparam logic [StgW-1:0] LastStage  = StgW'(NumDomains - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_IDLE    = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CntW-1:0]         r_cnt;
    logic [CntW-1:0]         w_cnt_next;
    logic [CntW-1:0]         w_cnt_inc;
    logic [StgW-1:0]         r_stage;
    logic [StgW-1:0]         w_stage_next;
    logic [NumDomains-1:0]   r_domain_rst_n;
    logic [NumDomains-1:0]   w_domain_next;
    logic                    r_busy;
    logic                    w_busy_next;
    logic [NumReq-1:0]       r_cause;
    logic [NumReq-1:0]       w_cause_next;
    logic [NumReq-1:0]       r_last;
    logic [NumReq-1:0]       w_last_next;
    logic                    w_req_any;
    logic                    w_release;     // release domain r_stage on this edge
    logic                    w_assert_all;  // drive every domain back into reset

    assign w_req_any = |rst_req_i;

    // Counter never wraps; it parks at its largest value.
    assign w_cnt_inc = (r_cnt == CntSat) ? r_cnt : r_cnt + CntW'(1);

    // Set wins over clear, so a request in the clear cycle is not lost.
    assign w_cause_next = (cause_clr_i ? '0 : r_cause) | rst_req_i;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stage_next = r_stage;
        w_busy_next  = r_busy;
        w_last_next  = r_last;
        w_release    = 1'b0;
        w_assert_all = 1'b0;

        case (r_state)
            ST_ASSERT: begin
                // Requests during the hold add to the cause of this sequence.
                w_last_next = r_last | rst_req_i;
                if (w_req_any) begin
                    w_cnt_next = '0;
                end else if (r_cnt == AssertLast) begin
                    w_release    = 1'b1;
                    w_cnt_next   = '0;
                    w_stage_next = StgW'(1);
                    if (NumDomains == 1) begin
                        w_state_next = ST_IDLE;
                        w_busy_next  = 1'b0;
                    end else begin
                        w_state_next = ST_RELEASE;
                    end
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end

            ST_RELEASE: begin
                if (w_req_any) begin
                    // Abort: a fresh sequence, caused only by this request.
                    w_state_next = ST_ASSERT;
                    w_cnt_next   = '0;
                    w_stage_next = '0;
                    w_assert_all = 1'b1;
                    w_busy_next  = 1'b1;
                    w_last_next  = rst_req_i;
                end else if (r_cnt == GapLast) begin
                    w_release    = 1'b1;
                    w_cnt_next   = '0;
                    w_stage_next = r_stage + StgW'(1);
                    if (r_stage == LastStage) begin
                        w_state_next = ST_IDLE;
                        w_busy_next  = 1'b0;
                    end
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end

            ST_IDLE: begin
                if (w_req_any) begin
                    w_state_next = ST_ASSERT;
                    w_cnt_next   = '0;
                    w_stage_next = '0;
                    w_assert_all = 1'b1;
                    w_busy_next  = 1'b1;
                    w_last_next  = rst_req_i;
                end
            end

            default: begin
                w_state_next = ST_ASSERT;
                w_cnt_next   = '0;
                w_stage_next = '0;
                w_assert_all = 1'b1;
                w_busy_next  = 1'b1;
            end
        endcase
    end

    // Each domain, once released, stays released until the whole set is
    // re-asserted; only the domain selected by the stage index can rise.
    for (genvar gi = 0; gi < NumDomains; gi++) begin : g_domain
        assign w_domain_next[gi] = ~w_assert_all &
                                   (r_domain_rst_n[gi] |
                                    (w_release & (r_stage == StgW'(gi))));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= ST_ASSERT;
            r_cnt          <= '0;
            r_stage        <= '0;
            r_domain_rst_n <= '0;
            r_busy         <= 1'b1;
            r_cause        <= '0;
            r_last         <= '0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_stage        <= w_stage_next;
            r_domain_rst_n <= w_domain_next;
            r_busy         <= w_busy_next;
            r_cause        <= w_cause_next;
            r_last         <= w_last_next;
        end
    end

    assign domain_rst_no = r_domain_rst_n;
    assign seq_busy_o    = r_busy;
    assign rst_cause_o   = r_cause;
    assign last_cause_o  = r_last;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Two instances share clock, reset and inputs: the default configuration and a
// single-domain configuration with the shortest legal hold and gap. The
// reference model reduces the sequencer to one number per instance: how many
// consecutive request-free edges have passed since the last request (or since
// reset). Domain k is released once that number reaches AssertCycles +
// k*StageGap; the hold is still running while it is below AssertCycles.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int A0 = 16, G0 = 8, N0 = 3, R0 = 4;
    localparam int A1 = 1,  G1 = 1, N1 = 1, R1 = 2;
    localparam int QCap = 1000;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [3:0]    rst_req;
    logic          cause_clr;

    logic [N0-1:0] d0_dom;
    logic          d0_busy;
    logic [R0-1:0] d0_cause;
    logic [R0-1:0] d0_last;
    logic [N1-1:0] d1_dom;
    logic          d1_busy;
    logic [R1-1:0] d1_cause;
    logic [R1-1:0] d1_last;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model state
    int            q0, q1;
    logic [R0-1:0] m_cause0, m_last0;
    logic [R1-1:0] m_cause1, m_last1;

    always #5 clk_i = ~clk_i;

    reset_sequencer #(
        .NumReq(R0), .NumDomains(N0), .AssertCycles(A0), .StageGap(G0)
    ) u_dut0 (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rst_req_i     (rst_req),
        .cause_clr_i   (cause_clr),
        .domain_rst_no (d0_dom),
        .seq_busy_o    (d0_busy),
        .rst_cause_o   (d0_cause),
        .last_cause_o  (d0_last)
    );

    reset_sequencer #(
        .NumReq(R1), .NumDomains(N1), .AssertCycles(A1), .StageGap(G1)
    ) u_dut1 (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rst_req_i     (rst_req[1:0]),
        .cause_clr_i   (cause_clr),
        .domain_rst_no (d1_dom),
        .seq_busy_o    (d1_busy),
        .rst_cause_o   (d1_cause),
        .last_cause_o  (d1_last)
    );

    function automatic logic [7:0] exp_dom(input int q, input int a, input int g, input int n);
        logic [7:0] d;
        d = '0;
        for (int k = 0; k < n; k++) begin
            if (q >= a + k * g) d[k] = 1'b1;
        end
        return d;
    endfunction

    function automatic logic exp_busy(input int q, input int a, input int g, input int n);
        return (q < a + (n - 1) * g);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: quiet-edge counters plus cause registers.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q0 <= 0; m_cause0 <= '0; m_last0 <= '0;
            q1 <= 0; m_cause1 <= '0; m_last1 <= '0;
        end else begin
            m_cause0 <= (cause_clr ? 4'b0 : m_cause0) | rst_req;
            m_cause1 <= (cause_clr ? 2'b0 : m_cause1) | rst_req[1:0];
            if (rst_req != 0) begin
                q0      <= 0;
                m_last0 <= (q0 < A0) ? (m_last0 | rst_req) : rst_req;
            end else if (q0 < QCap) begin
                q0 <= q0 + 1;
            end
            if (rst_req[1:0] != 0) begin
                q1      <= 0;
                m_last1 <= (q1 < A1) ? (m_last1 | rst_req[1:0]) : rst_req[1:0];
            end else if (q1 < QCap) begin
                q1 <= q1 + 1;
            end
        end
    end

    // Per-cycle comparison against the model, half a period after the edge.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("dom0",   8'(d0_dom),   exp_dom(q0, A0, G0, N0));
            check("busy0",  8'(d0_busy),  8'(exp_busy(q0, A0, G0, N0)));
            check("cause0", 8'(d0_cause), 8'(m_cause0));
            check("last0",  8'(d0_last),  8'(m_last0));
            check("dom1",   8'(d1_dom),   exp_dom(q1, A1, G1, N1));
            check("busy1",  8'(d1_busy),  8'(exp_busy(q1, A1, G1, N1)));
            check("cause1", 8'(d1_cause), 8'(m_cause1));
            check("last1",  8'(d1_last),  8'(m_last1));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Power-on timeline, starting just after rst_ni rises between edges.
    task automatic power_on_checks(input string tag);
        step(15);
        check({tag, "_dom_e15"},  8'(d0_dom),  8'b000);
        check({tag, "_busy_e15"}, 8'(d0_busy), 8'd1);
        step(1);
        check({tag, "_dom_e16"},  8'(d0_dom),  8'b001);
        step(8);
        check({tag, "_dom_e24"},  8'(d0_dom),  8'b011);
        step(7);
        check({tag, "_busy_e31"}, 8'(d0_busy), 8'd1);
        step(1);
        check({tag, "_dom_e32"},  8'(d0_dom),  8'b111);
        check({tag, "_busy_e32"}, 8'(d0_busy), 8'd0);
        check({tag, "_cause"},    8'(d0_cause), 8'b0000);
    endtask

    task automatic async_reset_checks(input string tag);
        check({tag, "_dom"},   8'(d0_dom),   8'b000);
        check({tag, "_busy"},  8'(d0_busy),  8'd1);
        check({tag, "_cause"}, 8'(d0_cause), 8'b0000);
        check({tag, "_last"},  8'(d0_last),  8'b0000);
        check({tag, "_dom1"},  8'(d1_dom),   8'b0);
    endtask

    initial begin
        int rate;
        bit hit;
        rst_ni    = 1'b1;
        rst_req   = '0;
        cause_clr = 1'b0;
        rate      = 0;
        #2 rst_ni = 1'b0;
        #1 chk_en = 1'b1;
        async_reset_checks("reset");
        step(3);
        #2 rst_ni = 1'b1;

        // Power-on sequence with no requests.
        power_on_checks("po");

        // Single-cycle request from IDLE.
        rst_req = 4'b0010;
        step(1);
        rst_req = '0;
        check("idle_req_dom",   8'(d0_dom),   8'b000);
        check("idle_req_busy",  8'(d0_busy),  8'd1);
        check("idle_req_last",  8'(d0_last),  8'b0010);
        check("idle_req_cause", 8'(d0_cause), 8'b0010);
        step(15);
        check("idle_req_t16", 8'(d0_dom), 8'b000);
        step(1);
        check("idle_req_t17", 8'(d0_dom), 8'b001);
        step(8);
        check("idle_req_t25", 8'(d0_dom), 8'b011);
        step(8);
        check("idle_req_t33", 8'(d0_dom), 8'b111);

        // Clear and set in the same cycle: the set wins.
        rst_req = 4'b0100;
        step(1);
        rst_req = '0;
        check("pre_clr_cause", 8'(d0_cause), 8'b0110);
        cause_clr = 1'b1;
        rst_req   = 4'b0001;
        step(1);
        cause_clr = 1'b0;
        rst_req   = '0;
        check("clr_set_cause", 8'(d0_cause), 8'b0001);
        check("clr_set_last",  8'(d0_last),  8'b0101);
        step(40);
        check("clr_idle_busy", 8'(d0_busy), 8'd0);

        // Request extended during the hold.
        rst_req = 4'b0001;
        step(1);
        rst_req = '0;
        step(9);
        rst_req = 4'b0100;
        step(1);
        rst_req = '0;
        step(15);
        check("extend_t26", 8'(d0_dom), 8'b000);
        step(1);
        check("extend_t27",      8'(d0_dom),  8'b001);
        check("extend_last",     8'(d0_last), 8'b0101);
        step(8);
        check("extend_dom1_rel", 8'(d0_dom),  8'b011);

        // Abort during the staged release.
        rst_req = 4'b1000;
        step(1);
        rst_req = '0;
        check("abort_dom",   8'(d0_dom),   8'b000);
        check("abort_busy",  8'(d0_busy),  8'd1);
        check("abort_last",  8'(d0_last),  8'b1000);
        check("abort_cause", 8'(d0_cause), 8'b1101);
        step(15);
        check("abort_t16", 8'(d0_dom), 8'b000);
        step(1);
        check("abort_t17", 8'(d0_dom), 8'b001);

        // Asynchronous reset mid-release, then a fresh power-on sequence.
        step(4);
        #2 rst_ni = 1'b0;
        #1 async_reset_checks("midrel_rst");
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        power_on_checks("po2");

        // Randomized phase, varying request density in windows.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_i);
            if (cyc % 150 == 0) rate = $urandom_range(0, 2);
            case (rate)
                0:       hit = ($urandom_range(0, 199) == 0);
                1:       hit = ($urandom_range(0, 59) == 0);
                default: hit = ($urandom_range(0, 3) == 0);
            endcase
            rst_req   = hit ? 4'($urandom_range(1, 15)) : 4'b0000;
            cause_clr = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_ni = 1'b0;
                #1 check("rnd_rst_dom",  8'(d0_dom),  8'b000);
                check("rnd_rst_busy", 8'(d0_busy), 8'd1);
                @(negedge clk_i);
                #2 rst_ni = 1'b1;
            end
        end
        @(negedge clk_i);
        rst_req   = '0;
        cause_clr = 1'b0;
        step(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NumReq, default 4: number of reset requesters (legal 1..8).
REQ-002 Parameter NumDomains, default 3: number of staged reset domains (legal 1..8).
REQ-003 Parameter AssertCycles, default 16: minimum cycles all domains are held in reset (legal >= 1).
REQ-004 Parameter StageGap, default 8: cycles between successive domain releases (legal >= 1).
REQ-005 clk_i  input  1  single clock for all state.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 rst_req_i  input  NumReq  level requests, already synchronous to clk_i; bit i high = requester i wants reset.
REQ-008 cause_clr_i  input  1  single-cycle pulse that clears rst_cause_o.
REQ-009 domain_rst_no  output  NumDomains  active-low domain resets; bit 0 is released first.
REQ-010 seq_busy_o  output  1  high while any domain is in reset or release is in progress.
REQ-011 rst_cause_o  output  NumReq  sticky OR of every request seen since the last clear.
REQ-012 last_cause_o  output  NumReq  requests that started or extended the most recent sequence.

Function
REQ-013 All outputs SHALL be driven directly from flops, with no combinational path from inputs.
REQ-014 FSM SHALL have exactly three states: ASSERT, RELEASE, IDLE.
REQ-015 ASSERT: all domain_rst_no bits 0; counter increments each cycle in which rst_req_i == 0.
REQ-016 Any cycle in ASSERT with rst_req_i != 0 SHALL reset the counter to 0, extending the hold.
REQ-017 ASSERT -> RELEASE when the counter reaches AssertCycles; domain 0 SHALL go high on that transition edge.
REQ-018 RELEASE: domain k SHALL go high exactly StageGap cycles after domain k-1; released domains stay high.
REQ-019 RELEASE -> IDLE on the edge that releases domain NumDomains-1; seq_busy_o SHALL fall on the same edge.
REQ-020 With NumDomains == 1, ASSERT SHALL go directly to IDLE, releasing domain 0.
REQ-021 IDLE: rst_req_i != 0 in cycle t SHALL give all domain_rst_no == 0 and seq_busy_o == 1 from cycle t+1 (state ASSERT, counter 0).
REQ-022 RELEASE with rst_req_i != 0 SHALL abort: re-assert all domains next cycle and re-enter ASSERT with counter 0.
REQ-023 Timing: last request-high cycle t_last gives domain 0 high at t_last+AssertCycles+1 and domain k high at t_last+AssertCycles+1+k*StageGap.
REQ-024 rst_cause_o SHALL OR in rst_req_i every cycle, in any state.
REQ-025 cause_clr_i SHALL zero rst_cause_o next cycle, except for bits set by rst_req_i in the same cycle; set wins.
REQ-026 last_cause_o SHALL load rst_req_i on IDLE->ASSERT and RELEASE->ASSERT; in ASSERT it SHALL OR in rst_req_i.
REQ-027 last_cause_o SHALL be unaffected by cause_clr_i.
REQ-028 Counter width SHALL be $clog2(max(AssertCycles,StageGap)+1), with no wrap: it saturates and stops at its terminal count.
REQ-029 A stage index of $clog2(NumDomains+1) bits SHALL track the next domain to release.

Reset
REQ-030 While rst_ni == 0, asynchronously: state ASSERT, counter 0, stage index 0, domain_rst_no all 0, seq_busy_o 1, rst_cause_o 0, last_cause_o 0.
REQ-031 After rst_ni rises with rst_req_i == 0, the first clock edge counts as ASSERT cycle 1.
REQ-032 After rst_ni rises with rst_req_i == 0, domain 0 SHALL release on the AssertCycles-th edge, giving a power-on sequence.
REQ-033 rst_ni asserted mid-sequence SHALL immediately force all REQ-030 values, regardless of state.

Verification
REQ-034 Power-on, defaults, no requests -> domain_rst_no 000 until edge 16, then 001 at edge 16, 011 at 24, 111 at 32; seq_busy_o falls at 32; rst_cause_o 0.
REQ-035 IDLE, rst_req_i=0010 for one cycle at t -> domain_rst_no 000 at t+1, bit0 high at t+17, bit1 at t+25, bit2 at t+33; last_cause_o 0010, rst_cause_o 0010.
REQ-036 Request 0001 at t, then 0100 at t+10 (in ASSERT) -> domain 0 releases at t+27; last_cause_o 0101.
REQ-037 Request 1000 in RELEASE just after domain 1 is released -> all domains 0 next cycle; full sequence restarts; last_cause_o 1000; rst_cause_o keeps prior bits.
REQ-038 cause_clr_i and rst_req_i=0001 in the same cycle, with rst_cause_o=0110 -> rst_cause_o 0001 next cycle.
REQ-039 rst_ni pulsed low mid-RELEASE -> outputs match REQ-030 asynchronously, without waiting for a clock edge; power-on timing per REQ-034 follows.
